// File: rtl/ex_pkg.sv
// Shared encodings for the execute stage: ALU codes, RV32M funct3 values,
// MDU FSM states and ALU operand-B selector codes.
package ex_pkg;

  localparam logic [3:0] ALU_ADD   = 4'd0;
  localparam logic [3:0] ALU_SUB   = 4'd1;
  localparam logic [3:0] ALU_SLL   = 4'd2;
  localparam logic [3:0] ALU_SLT   = 4'd3;
  localparam logic [3:0] ALU_SLTU  = 4'd4;
  localparam logic [3:0] ALU_XOR   = 4'd5;
  localparam logic [3:0] ALU_SRL   = 4'd6;
  localparam logic [3:0] ALU_SRA   = 4'd7;
  localparam logic [3:0] ALU_OR    = 4'd8;
  localparam logic [3:0] ALU_AND   = 4'd9;
  localparam logic [3:0] ALU_PASSB = 4'd10;

  typedef enum logic [2:0] {
    MDU_MUL    = 3'd0,
    MDU_MULH   = 3'd1,
    MDU_MULHSU = 3'd2,
    MDU_MULHU  = 3'd3,
    MDU_DIV    = 3'd4,
    MDU_DIVU   = 3'd5,
    MDU_REM    = 3'd6,
    MDU_REMU   = 3'd7
  } mdu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } mdu_state_e;

  localparam logic [1:0] SRCB_RS2  = 2'd0;
  localparam logic [1:0] SRCB_IMM  = 2'd1;
  localparam logic [1:0] SRCB_FOUR = 2'd2;

  function automatic logic op_is_div(input logic [2:0] op);
    return op[2];
  endfunction

  function automatic logic op_a_signed(input logic [2:0] op);
    return (op == MDU_MUL) || (op == MDU_MULH) || (op == MDU_MULHSU) ||
           (op == MDU_DIV) || (op == MDU_REM);
  endfunction

  function automatic logic op_b_signed(input logic [2:0] op);
    return (op == MDU_MUL) || (op == MDU_MULH) || (op == MDU_DIV) || (op == MDU_REM);
  endfunction

endpackage

// File: rtl/ex_mdu_stage_mdu_iter.sv
// Iterative RV32M unit: IDLE/BUSY/DONE FSM, shift-add multiplier and, when
// MDU_DIV_EN is defined, a restoring divider sharing the same accumulators.
module mdu_iter
  import ex_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            valid,
  input  logic            flush,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] opa,
  input  logic [XLEN-1:0] opb,
  output logic            stall,
  output logic            done,
  output logic            illegal,
  output logic [XLEN-1:0] result
);
  localparam int CNT_W = $clog2(XLEN);

  mdu_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [XLEN-1:0]   hi_q, hi_d, lo_q, lo_d, opnd_q, opnd_d;
  mdu_op_e           op_q, op_d;
  logic              neg_q, neg_d;
  logic              op_ok, issue, a_sgn, b_sgn;
  logic [XLEN-1:0]   a_mag, b_mag;
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] prod_s;
`ifdef MDU_DIV_EN
  logic              rneg_q, rneg_d, div0_q, div0_d;
  logic [XLEN-1:0]   araw_q, araw_d;
  logic [XLEN:0]     div_shift, div_diff;

  assign op_ok     = 1'b1;
  assign div_shift = {hi_q, lo_q[XLEN-1]};
  assign div_diff  = div_shift - {1'b0, opnd_q};
`else
  assign op_ok     = !op_is_div(op);
`endif

  assign issue   = (state_q == ST_IDLE) && valid && !flush && op_ok;
  assign stall   = rst_n && (issue || ((state_q == ST_BUSY) && !flush));
  assign done    = (state_q == ST_DONE) && !flush;
  assign illegal = rst_n && (state_q == ST_IDLE) && valid && !flush && !op_ok;

  assign a_sgn   = op_a_signed(op) && opa[XLEN-1];
  assign b_sgn   = op_b_signed(op) && opb[XLEN-1];
  assign a_mag   = a_sgn ? -opa : opa;
  assign b_mag   = b_sgn ? -opb : opb;
  assign mul_sum = {1'b0, hi_q} + {1'b0, (lo_q[0] ? opnd_q : '0)};
  assign prod_s  = neg_q ? -{hi_q, lo_q} : {hi_q, lo_q};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    opnd_d  = opnd_q;
    op_d    = op_q;
    neg_d   = neg_q;
`ifdef MDU_DIV_EN
    rneg_d  = rneg_q;
    div0_d  = div0_q;
    araw_d  = araw_q;
`endif
    unique case (state_q)
      ST_IDLE: if (issue) begin
        state_d = ST_BUSY;
        cnt_d   = CNT_W'(XLEN - 1);
        op_d    = mdu_op_e'(op);
        neg_d   = a_sgn ^ b_sgn;
        hi_d    = '0;
        // Multiply keeps the multiplier in lo; divide shifts the dividend out of lo.
        opnd_d  = op_is_div(op) ? b_mag : a_mag;
        lo_d    = op_is_div(op) ? a_mag : b_mag;
`ifdef MDU_DIV_EN
        rneg_d  = a_sgn;
        div0_d  = (opb == '0);
        araw_d  = opa;
`endif
      end
      ST_BUSY: if (flush) begin
        state_d = ST_IDLE;
      end else begin
`ifdef MDU_DIV_EN
        if (op_is_div(op_q)) begin
          hi_d = div_diff[XLEN] ? div_shift[XLEN-1:0] : div_diff[XLEN-1:0];
          lo_d = {lo_q[XLEN-2:0], !div_diff[XLEN]};
        end else
`endif
        begin
          hi_d = mul_sum[XLEN:1];
          lo_d = {mul_sum[0], lo_q[XLEN-1:1]};
        end
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == '0) state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    result = prod_s[XLEN-1:0];
    unique case (op_q)
      MDU_MULH, MDU_MULHSU, MDU_MULHU: result = prod_s[2*XLEN-1:XLEN];
`ifdef MDU_DIV_EN
      // Divide by zero bypasses sign fix-up: quotient -1, remainder = dividend.
      MDU_DIV, MDU_DIVU: result = div0_q ? '1 : (neg_q ? -lo_q : lo_q);
      MDU_REM, MDU_REMU: result = div0_q ? araw_q : (rneg_q ? -hi_q : hi_q);
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      opnd_q  <= '0;
      op_q    <= MDU_MUL;
      neg_q   <= 1'b0;
`ifdef MDU_DIV_EN
      rneg_q  <= 1'b0;
      div0_q  <= 1'b0;
      araw_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      opnd_q  <= opnd_d;
      op_q    <= op_d;
      neg_q   <= neg_d;
`ifdef MDU_DIV_EN
      rneg_q  <= rneg_d;
      div0_q  <= div0_d;
      araw_q  <= araw_d;
`endif
    end
  end

endmodule

// File: rtl/ex_mdu_stage.sv
// RV32M execute stage: MEM/WB operand forwarding, single-cycle ALU and an
// iterative MDU with stall handshake. Divider is built only with MDU_DIV_EN.
module ex_mdu_stage
  import ex_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int RADDR_W = 5,
  parameter int ALUC_W  = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [ALUC_W-1:0]  ALUCode_ex,
  input  logic               ALUSrcA_ex,
  input  logic [1:0]         ALUSrcB_ex,
  input  logic               MduValid_ex,
  input  logic [2:0]         MduOp_ex,
  input  logic               Flush_ex,
  input  logic [XLEN-1:0]    Imm_ex,
  input  logic [XLEN-1:0]    PC_ex,
  input  logic [RADDR_W-1:0] rs1Addr_ex,
  input  logic [RADDR_W-1:0] rs2Addr_ex,
  input  logic [XLEN-1:0]    rs1Data_ex,
  input  logic [XLEN-1:0]    rs2Data_ex,
  input  logic [XLEN-1:0]    ALUResult_mem,
  input  logic [XLEN-1:0]    RegWriteData_wb,
  input  logic [RADDR_W-1:0] rdAddr_mem,
  input  logic [RADDR_W-1:0] rdAddr_wb,
  input  logic               RegWrite_mem,
  input  logic               RegWrite_wb,
  output logic [XLEN-1:0]    ALUResult_ex,
  output logic [XLEN-1:0]    MemWriteData_ex,
  output logic               Stall_ex,
  output logic               MduDone_ex,
  output logic               IllegalOp_ex
);
  localparam int SH_W = $clog2(XLEN);

  logic [XLEN-1:0] fwd_a, fwd_b, alu_a, alu_b, alu_out, mdu_result;
  logic            mdu_illegal;

  // MEM wins over WB; x0 is never forwarded.
  always_comb begin
    fwd_a = rs1Data_ex;
    if (RegWrite_mem && (rdAddr_mem != '0) && (rdAddr_mem == rs1Addr_ex))
      fwd_a = ALUResult_mem;
    else if (RegWrite_wb && (rdAddr_wb != '0) && (rdAddr_wb == rs1Addr_ex))
      fwd_a = RegWriteData_wb;
    fwd_b = rs2Data_ex;
    if (RegWrite_mem && (rdAddr_mem != '0) && (rdAddr_mem == rs2Addr_ex))
      fwd_b = ALUResult_mem;
    else if (RegWrite_wb && (rdAddr_wb != '0) && (rdAddr_wb == rs2Addr_ex))
      fwd_b = RegWriteData_wb;
  end

  always_comb begin
    alu_a = ALUSrcA_ex ? PC_ex : fwd_a;
    unique case (ALUSrcB_ex)
      SRCB_RS2:  alu_b = fwd_b;
      SRCB_IMM:  alu_b = Imm_ex;
      SRCB_FOUR: alu_b = XLEN'(4);
      default:   alu_b = '0;
    endcase
  end

  always_comb begin
    unique case (ALUCode_ex)
      ALU_ADD:   alu_out = alu_a + alu_b;
      ALU_SUB:   alu_out = alu_a - alu_b;
      ALU_SLL:   alu_out = alu_a << alu_b[SH_W-1:0];
      ALU_SLT:   alu_out = {{(XLEN-1){1'b0}}, $signed(alu_a) < $signed(alu_b)};
      ALU_SLTU:  alu_out = {{(XLEN-1){1'b0}}, alu_a < alu_b};
      ALU_XOR:   alu_out = alu_a ^ alu_b;
      ALU_SRL:   alu_out = alu_a >> alu_b[SH_W-1:0];
      ALU_SRA:   alu_out = $signed(alu_a) >>> alu_b[SH_W-1:0];
      ALU_OR:    alu_out = alu_a | alu_b;
      ALU_AND:   alu_out = alu_a & alu_b;
      ALU_PASSB: alu_out = alu_b;
      default:   alu_out = '0;
    endcase
  end

  mdu_iter #(.XLEN(XLEN)) u_mdu (
    .clk     (clk),
    .rst_n   (rst_n),
    .valid   (MduValid_ex),
    .flush   (Flush_ex),
    .op      (MduOp_ex),
    .opa     (fwd_a),
    .opb     (fwd_b),
    .stall   (Stall_ex),
    .done    (MduDone_ex),
    .illegal (mdu_illegal),
    .result  (mdu_result)
  );

  assign IllegalOp_ex    = mdu_illegal;
  assign MemWriteData_ex = fwd_b;
  assign ALUResult_ex    = MduDone_ex ? mdu_result : (mdu_illegal ? '0 : alu_out);

endmodule

// File: tb/tb_ex_mdu_stage.sv
// Directed bench for ex_mdu_stage with a cycle-level reference model and
// literal expectations; adapts to builds with or without MDU_DIV_EN.
module tb_ex_mdu_stage;
  import ex_pkg::*;

`ifdef MDU_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif
  localparam int LAT = 33;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  ALUCode_ex;
  logic        ALUSrcA_ex;
  logic [1:0]  ALUSrcB_ex;
  logic        MduValid_ex;
  logic [2:0]  MduOp_ex;
  logic        Flush_ex;
  logic [31:0] Imm_ex, PC_ex, rs1Data_ex, rs2Data_ex, ALUResult_mem, RegWriteData_wb;
  logic [4:0]  rs1Addr_ex, rs2Addr_ex, rdAddr_mem, rdAddr_wb;
  logic        RegWrite_mem, RegWrite_wb;
  logic [31:0] ALUResult_ex, MemWriteData_ex;
  logic        Stall_ex, MduDone_ex, IllegalOp_ex;

  int checks = 0;
  int errors = 0;

  ex_mdu_stage dut (
    .clk(clk), .rst_n(rst_n), .ALUCode_ex(ALUCode_ex), .ALUSrcA_ex(ALUSrcA_ex),
    .ALUSrcB_ex(ALUSrcB_ex), .MduValid_ex(MduValid_ex), .MduOp_ex(MduOp_ex),
    .Flush_ex(Flush_ex), .Imm_ex(Imm_ex), .PC_ex(PC_ex), .rs1Addr_ex(rs1Addr_ex),
    .rs2Addr_ex(rs2Addr_ex), .rs1Data_ex(rs1Data_ex), .rs2Data_ex(rs2Data_ex),
    .ALUResult_mem(ALUResult_mem), .RegWriteData_wb(RegWriteData_wb),
    .rdAddr_mem(rdAddr_mem), .rdAddr_wb(rdAddr_wb), .RegWrite_mem(RegWrite_mem),
    .RegWrite_wb(RegWrite_wb), .ALUResult_ex(ALUResult_ex),
    .MemWriteData_ex(MemWriteData_ex), .Stall_ex(Stall_ex), .MduDone_ex(MduDone_ex),
    .IllegalOp_ex(IllegalOp_ex)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] fwd(input logic [4:0] a, input logic [31:0] rf);
    if (RegWrite_mem && rdAddr_mem != 5'd0 && rdAddr_mem == a) return ALUResult_mem;
    if (RegWrite_wb && rdAddr_wb != 5'd0 && rdAddr_wb == a) return RegWriteData_wb;
    return rf;
  endfunction

  function automatic logic [31:0] alu_model();
    logic [31:0] a, b;
    a = ALUSrcA_ex ? PC_ex : fwd(rs1Addr_ex, rs1Data_ex);
    case (ALUSrcB_ex)
      2'd0: b = fwd(rs2Addr_ex, rs2Data_ex);
      2'd1: b = Imm_ex;
      2'd2: b = 32'd4;
      default: b = 32'd0;
    endcase
    case (ALUCode_ex)
      ALU_ADD:   return a + b;
      ALU_SUB:   return a - b;
      ALU_SLL:   return a << b[4:0];
      ALU_SLT:   return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      ALU_SLTU:  return (a < b) ? 32'd1 : 32'd0;
      ALU_XOR:   return a ^ b;
      ALU_SRL:   return a >> b[4:0];
      ALU_SRA:   return $signed(a) >>> b[4:0];
      ALU_OR:    return a | b;
      ALU_AND:   return a & b;
      ALU_PASSB: return b;
      default:   return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] mdu_model(input logic [2:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    longint sa, sb, sp, q;
    longint unsigned ua, ub, up;
    sa = $signed(a); sb = $signed(b);
    ua = {32'd0, a}; ub = {32'd0, b};
    case (op)
      3'd0: begin sp = sa * sb; return sp[31:0]; end
      3'd1: begin sp = sa * sb; return sp[63:32]; end
      3'd2: begin sp = sa * longint'(ub); return sp[63:32]; end
      3'd3: begin up = ua * ub; return up[63:32]; end
      3'd4: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        q = sa / sb; return q[31:0];
      end
      3'd5: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        up = ua / ub; return up[31:0];
      end
      3'd6: begin
        if (b == 32'd0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        q = sa % sb; return q[31:0];
      end
      default: begin
        if (b == 32'd0) return a;
        up = ua % ub; return up[31:0];
      end
    endcase
  endfunction

  function automatic bit op_legal(input logic [2:0] op);
    return DIV_EN || !op[2];
  endfunction

  // Reference model: an issued op occupies XLEN busy cycles then one result cycle.
  bit          m_pend = 1'b0;
  int          m_age  = 0;
  logic [31:0] m_res  = 32'd0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pend = 1'b0;
    end else if (!m_pend) begin
      if (MduValid_ex && !Flush_ex && op_legal(MduOp_ex)) begin
        m_pend = 1'b1;
        m_age  = 1;
        m_res  = mdu_model(MduOp_ex, fwd(rs1Addr_ex, rs1Data_ex), fwd(rs2Addr_ex, rs2Data_ex));
      end
    end else if (Flush_ex || m_age == LAT) begin
      m_pend = 1'b0;
    end else begin
      m_age++;
    end
  end

  always @(negedge clk) begin : cmp
    logic e_stall, e_done, e_ill, use_res;
    logic [31:0] e_res;
    if (rst_n) begin
      e_res = 32'd0;
      if (!m_pend) begin
        e_stall = MduValid_ex && !Flush_ex && op_legal(MduOp_ex);
        e_ill   = MduValid_ex && !Flush_ex && !op_legal(MduOp_ex);
        e_done  = 1'b0;
        e_res   = e_ill ? 32'd0 : alu_model();
        use_res = !e_stall;
      end else if (m_age < LAT) begin
        e_stall = !Flush_ex; e_ill = 1'b0; e_done = 1'b0; use_res = 1'b0;
      end else begin
        e_stall = 1'b0; e_ill = 1'b0; e_done = !Flush_ex;
        e_res = m_res; use_res = !Flush_ex;
      end
      chk("cmp_stall", {31'd0, Stall_ex}, {31'd0, e_stall});
      chk("cmp_done", {31'd0, MduDone_ex}, {31'd0, e_done});
      chk("cmp_illegal", {31'd0, IllegalOp_ex}, {31'd0, e_ill});
      chk("cmp_memwdata", MemWriteData_ex, fwd(rs2Addr_ex, rs2Data_ex));
      if (use_res) chk("cmp_result", ALUResult_ex, e_res);
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic set_ops(input logic [31:0] a, input logic [31:0] b);
    RegWrite_mem = 1'b0; RegWrite_wb = 1'b0;
    rs1Addr_ex = 5'd1; rs2Addr_ex = 5'd2;
    rs1Data_ex = a; rs2Data_ex = b;
  endtask

  task automatic mdu_run(input logic [2:0] op, input bit perturb, output logic [31:0] res,
                         output int lat, output int stalls);
    bit got;
    got = 1'b0; lat = 0; stalls = 0; res = 32'd0;
    MduOp_ex = op; MduValid_ex = 1'b1;
    for (int i = 0; i < 60 && !got; i++) begin
      @(negedge clk);
      if (Stall_ex) stalls++;
      if (MduDone_ex) begin
        got = 1'b1; res = ALUResult_ex;
      end else begin
        lat++;
        step();
        if (perturb && i == 0) begin
          ALUResult_mem = 32'h64; rs1Data_ex = 32'h64; rs2Data_ex = 32'h64;
        end
      end
    end
    chk("mdu_done_seen", {31'd0, got}, 32'd1);
    step();
    MduValid_ex = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r;
    int lat, stalls;
    bit seen;
    rst_n = 1'b0;
    ALUCode_ex = ALU_ADD; ALUSrcA_ex = 1'b0; ALUSrcB_ex = 2'd0;
    MduValid_ex = 1'b0; MduOp_ex = 3'd0; Flush_ex = 1'b0;
    Imm_ex = 32'd0; PC_ex = 32'd0; rs1Data_ex = 32'd0; rs2Data_ex = 32'd0;
    ALUResult_mem = 32'd0; RegWriteData_wb = 32'd0;
    rs1Addr_ex = 5'd0; rs2Addr_ex = 5'd0; rdAddr_mem = 5'd0; rdAddr_wb = 5'd0;
    RegWrite_mem = 1'b0; RegWrite_wb = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_stall", {31'd0, Stall_ex}, 32'd0);
    chk("rst_done", {31'd0, MduDone_ex}, 32'd0);
    chk("rst_illegal", {31'd0, IllegalOp_ex}, 32'd0);
    step(); rst_n = 1'b1;

    // MEM has priority over WB for the same register
    rs1Addr_ex = 5'd5; rdAddr_mem = 5'd5; rdAddr_wb = 5'd5;
    RegWrite_mem = 1'b1; RegWrite_wb = 1'b1;
    ALUResult_mem = 32'h11; RegWriteData_wb = 32'h22; rs1Data_ex = 32'h99;
    rs2Addr_ex = 5'd0; rs2Data_ex = 32'd0;
    @(negedge clk); chk("fwd_mem_prio", ALUResult_ex, 32'h11);
    step();
    // x0 never forwarded
    rs1Addr_ex = 5'd0; rdAddr_mem = 5'd0; rdAddr_wb = 5'd3; rs1Data_ex = 32'h123;
    @(negedge clk); chk("fwd_x0", ALUResult_ex, 32'h123);
    step();
    rs1Addr_ex = 5'd6; rdAddr_mem = 5'd7; rdAddr_wb = 5'd6; RegWriteData_wb = 32'h50;
    ALUCode_ex = ALU_SUB; ALUSrcB_ex = 2'd1; Imm_ex = 32'h10;
    @(negedge clk); chk("fwd_wb_sub", ALUResult_ex, 32'h40);
    step();
    ALUSrcA_ex = 1'b1; PC_ex = 32'h1000; ALUSrcB_ex = 2'd2; ALUCode_ex = ALU_ADD;
    @(negedge clk); chk("pc_plus4", ALUResult_ex, 32'h1004);
    step();
    ALUSrcA_ex = 1'b0; ALUSrcB_ex = 2'd0; ALUCode_ex = ALU_AND;
    rs1Addr_ex = 5'd8; rs1Data_ex = 32'hFF0F; rs2Addr_ex = 5'd9; rs2Data_ex = 32'd1;
    rdAddr_mem = 5'd9; RegWrite_mem = 1'b1; ALUResult_mem = 32'hCAFE;
    @(negedge clk);
    chk("memwdata_fwd", MemWriteData_ex, 32'hCAFE);
    chk("and_fwd_b", ALUResult_ex, 32'hCA0E);
    step();
    set_ops(32'h8000_0000, 32'd0); ALUCode_ex = ALU_SRA; ALUSrcB_ex = 2'd1; Imm_ex = 32'd4;
    @(negedge clk); chk("sra", ALUResult_ex, 32'hF800_0000);
    step();
    ALUCode_ex = ALU_ADD; ALUSrcB_ex = 2'd0;

    set_ops(32'd7, 32'hFFFF_FFFD);
    mdu_run(MDU_MUL, 1'b0, r, lat, stalls);
    chk("mul_7_m3", r, 32'hFFFF_FFEB);
    chk("mul_latency", lat, LAT);
    chk("mul_stall_cycles", stalls, LAT);
    set_ops(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    mdu_run(MDU_MULHU, 1'b0, r, lat, stalls); chk("mulhu_max", r, 32'hFFFF_FFFE);
    mdu_run(MDU_MULH, 1'b0, r, lat, stalls);  chk("mulh_m1_m1", r, 32'h0);
    mdu_run(MDU_MULHSU, 1'b0, r, lat, stalls); chk("mulhsu_m1_max", r, 32'hFFFF_FFFF);
    // operands latched at issue; later forwarding changes must not matter
    set_ops(32'd0, 32'd5); RegWrite_mem = 1'b1; rdAddr_mem = 5'd1; ALUResult_mem = 32'd6;
    mdu_run(MDU_MUL, 1'b1, r, lat, stalls); chk("mul_latched", r, 32'd30);

`ifdef MDU_DIV_EN
    set_ops(32'h8000_0000, 32'hFFFF_FFFF);
    mdu_run(MDU_DIV, 1'b0, r, lat, stalls);  chk("div_ovf", r, 32'h8000_0000);
    mdu_run(MDU_REM, 1'b0, r, lat, stalls);  chk("rem_ovf", r, 32'h0);
    set_ops(32'd5, 32'd0);
    mdu_run(MDU_DIVU, 1'b0, r, lat, stalls); chk("divu_by0", r, 32'hFFFF_FFFF);
    mdu_run(MDU_REMU, 1'b0, r, lat, stalls); chk("remu_by0", r, 32'd5);
    set_ops(32'hFFFF_FFF9, 32'd2);
    mdu_run(MDU_DIV, 1'b0, r, lat, stalls);  chk("div_m7_2", r, 32'hFFFF_FFFD);
    mdu_run(MDU_REM, 1'b0, r, lat, stalls);  chk("rem_m7_2", r, 32'hFFFF_FFFF);
    set_ops(32'hFFFF_FFFB, 32'd0);
    mdu_run(MDU_DIV, 1'b0, r, lat, stalls);  chk("div_by0_s", r, 32'hFFFF_FFFF);
    mdu_run(MDU_REM, 1'b0, r, lat, stalls);  chk("rem_by0_s", r, 32'hFFFF_FFFB);
`else
    set_ops(32'd100, 32'd7); MduOp_ex = MDU_DIV; MduValid_ex = 1'b1;
    @(negedge clk);
    chk("illegal_flag", {31'd0, IllegalOp_ex}, 32'd1);
    chk("illegal_stall", {31'd0, Stall_ex}, 32'd0);
    chk("illegal_result", ALUResult_ex, 32'd0);
    step(); MduValid_ex = 1'b0;
    @(negedge clk); chk("illegal_one_cycle", {31'd0, IllegalOp_ex}, 32'd0);
    step();
`endif

    // flush at busy cycle 10
    set_ops(32'd3, 32'd4); MduOp_ex = MDU_MUL; MduValid_ex = 1'b1;
    repeat (10) step();
    Flush_ex = 1'b1;
    @(negedge clk);
    chk("flush_stall", {31'd0, Stall_ex}, 32'd0);
    chk("flush_done", {31'd0, MduDone_ex}, 32'd0);
    step(); Flush_ex = 1'b0; MduValid_ex = 1'b0;
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (MduDone_ex || Stall_ex) seen = 1'b1;
      step();
    end
    chk("flush_quiet", {31'd0, seen}, 32'd0);

    // asynchronous reset mid-busy
    set_ops(32'd9, 32'd9); MduOp_ex = MDU_MUL; MduValid_ex = 1'b1;
    repeat (5) step();
    rst_n = 1'b0; #1;
    chk("rstmid_stall", {31'd0, Stall_ex}, 32'd0);
    chk("rstmid_done", {31'd0, MduDone_ex}, 32'd0);
    chk("rstmid_illegal", {31'd0, IllegalOp_ex}, 32'd0);
    MduValid_ex = 1'b0;
    step(); step(); rst_n = 1'b1;
    set_ops(32'hFFFF_FFFF, 32'd2);
    mdu_run(MDU_MUL, 1'b0, r, lat, stalls);
    chk("mul_after_rst", r, 32'hFFFF_FFFE);
    chk("lat_after_rst", lat, LAT);
    repeat (3) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
